// File: rtl/tcp_rx_read_scheduler.sv
// tcp_rx_read_scheduler: queues RX notifications and runs one read_package request at a time through to tlast.
// Define TCP_RX_SCHED_LEN_CHECK_EN to also flag reads whose received byte count differs from the notified length.
module tcp_rx_read_scheduler #(
  parameter int          NOTIF_DEPTH   = 16,
  parameter int          FIFO_THRESH   = 1000,
  parameter logic [31:0] TIMEOUT_CYCLE = 32'h0EE6_B280
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_notif_valid,
  output logic        s_notif_ready,
  input  logic [87:0] s_notif_data,
  output logic        m_read_pkg_valid,
  input  logic        m_read_pkg_ready,
  output logic [31:0] m_read_pkg_data,
  input  logic        rx_meta_valid,
  input  logic [15:0] rx_meta_session,
  input  logic        rx_data_fire,
  input  logic [63:0] rx_data_keep,
  input  logic        rx_data_last,
  input  logic [31:0] rx_fifo_count,
  output logic        busy,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_timeouts,
  output logic [31:0] stat_drops,
  output logic [31:0] stat_errors
);
  localparam int AW = $clog2(NOTIF_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_META = 2'd2, WAIT_DATA = 2'd3;
  logic [1:0]    state;
  logic [31:0]   q_mem [NOTIF_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   q_cnt;
  logic [15:0]   cur_session, cur_len, n_len;
  logic [31:0]   timer;
  logic          last_seen, full, empty, push, drop, pop, waiting, tap, last_now, done, tmo, sess_err, len_err;
  logic [32:0]   err_sum;
  logic          unused_notif;
  assign n_len = s_notif_data[31:16];
  assign unused_notif = ^s_notif_data[87:32];
  assign full = q_cnt == (AW+1)'(NOTIF_DEPTH);
  assign empty = q_cnt == '0;
  assign s_notif_ready = ~full;
  assign push = s_notif_valid & ~full & (n_len != 16'd0);
  assign drop = s_notif_valid & ~full & (n_len == 16'd0);
  assign pop = (state == IDLE) & ~empty & (rx_fifo_count <= 32'(FIFO_THRESH));
  assign waiting = (state == WAIT_META) | (state == WAIT_DATA);
  assign tap = rx_meta_valid | rx_data_fire;
  assign last_now = rx_data_fire & rx_data_last;
  // A last beat seen before metadata parks the read in WAIT_META until metadata completes it.
  assign done = ((state == WAIT_META) & rx_meta_valid & (last_seen | last_now)) | ((state == WAIT_DATA) & last_now);
  assign tmo = waiting & ~tap & (timer == TIMEOUT_CYCLE - 32'd1);
  assign sess_err = (state == WAIT_META) & rx_meta_valid & (rx_meta_session != cur_session);
  assign m_read_pkg_valid = state == ISSUE;
  assign m_read_pkg_data = {cur_len, cur_session};
  assign busy = state != IDLE;
`ifdef TCP_RX_SCHED_LEN_CHECK_EN
  logic [16:0] byte_cnt, byte_nxt;
  logic [17:0] byte_sum;
  logic [6:0]  pc;
  always_comb begin
    pc = '0;
    for (int i = 0; i < 64; i++) pc = pc + 7'(rx_data_keep[i]);
  end
  assign byte_sum = {1'b0, byte_cnt} + (rx_data_fire ? 18'(pc) : 18'd0);
  assign byte_nxt = byte_sum[17] ? '1 : byte_sum[16:0];
  assign len_err = done & (byte_nxt != {1'b0, cur_len});
  always_ff @(posedge clk) begin
    if (!rstn || state == ISSUE) byte_cnt <= '0;
    else if (busy) byte_cnt <= byte_nxt;
  end
`else
  logic unused_keep;
  assign unused_keep = ^rx_data_keep;
  assign len_err = 1'b0;
`endif
  assign err_sum = {1'b0, stat_errors} + 33'(sess_err) + 33'(len_err);
  always_ff @(posedge clk) if (push) q_mem[wr_ptr] <= s_notif_data[31:0];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt <= '0;
      cur_session <= '0;
      cur_len <= '0;
      timer <= '0;
      last_seen <= 1'b0;
      stat_reads <= '0;
      stat_timeouts <= '0;
      stat_drops <= '0;
      stat_errors <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      q_cnt <= q_cnt + (AW+1)'(push) - (AW+1)'(pop);
      timer <= (waiting & ~tap) ? timer + 32'd1 : 32'd0;
      last_seen <= (state == WAIT_META) & (last_seen | last_now);
      case (state)
        IDLE: if (pop) begin
          state <= ISSUE;
          cur_session <= q_mem[rd_ptr][15:0];
          cur_len <= q_mem[rd_ptr][31:16];
        end
        ISSUE: if (m_read_pkg_ready) state <= WAIT_META;
        WAIT_META: state <= (done | tmo) ? IDLE : rx_meta_valid ? WAIT_DATA : WAIT_META;
        default: state <= (done | tmo) ? IDLE : WAIT_DATA;
      endcase
      if (done && stat_reads != '1) stat_reads <= stat_reads + 32'd1;
      if (tmo && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 32'd1;
      if (drop && stat_drops != '1) stat_drops <= stat_drops + 32'd1;
      stat_errors <= err_sum[32] ? '1 : err_sum[31:0];
    end
  end
endmodule
